bpuf_eval_ctrl: RTL and testbench

//  Sequencer for a bank of bistable latch-pair PUF cells (excite/clk/Q per cell).

---
 rtl/bpuf_pkg.sv | 21 ++
 rtl/bpuf_sample_voter.sv | 76 +++++++
 rtl/bpuf_eval_ctrl.sv | 146 ++++++++++++++
 tb/tb_bpuf_eval_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/bpuf_pkg.sv
// Shared types and default timing for the bistable-latch PUF evaluation controller.
package bpuf_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXCITE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } state_e;

    localparam int DEF_N_CELLS    = 8;
    localparam int DEF_EXCITE_CYC = 4;
    localparam int DEF_SETTLE_CYC = 16;
    localparam int DEF_N_SAMPLES  = 7;

    function automatic int cnt_width(input int n_samples);
        return $clog2(n_samples + 1);
    endfunction

endpackage

// File: rtl/bpuf_sample_voter.sv
// Q synchronizer, ones counter and majority/stability vote for the selected PUF cell.
// Stability flag is built only when BPUF_STABILITY_CHECK_EN is defined.
module bpuf_sample_voter
    import bpuf_pkg::*;
#(
    parameter int N_CELLS   = DEF_N_CELLS,
    parameter int SEL_W     = $clog2(N_CELLS),
    parameter int N_SAMPLES = DEF_N_SAMPLES,
    parameter int CNT_W     = cnt_width(N_SAMPLES)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_CELLS-1:0] q_i,
    input  logic [SEL_W-1:0]   sel_i,
    input  logic               clear_i,
    input  logic               sample_i,
    input  logic               last_i,
    output logic               valid_o,
    output logic               resp_o,
    output logic [CNT_W-1:0]   ones_cnt_o,
    output logic               unstable_o
);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] ones_q;
    logic [CNT_W-1:0] ones_d;
    logic [CNT_W-1:0] cnt_out_q;
    logic             valid_q;
    logic             resp_q;

    // The last sample is folded in on the same edge that publishes the result.
    assign ones_d = ones_q + CNT_W'(sync_q[1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= '0;
            ones_q    <= '0;
            cnt_out_q <= '0;
            valid_q   <= 1'b0;
            resp_q    <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], q_i[sel_i]};
            valid_q <= last_i;
            if (clear_i) begin
                ones_q <= '0;
            end else if (sample_i) begin
                ones_q <= ones_d;
            end
            if (last_i) begin
                resp_q    <= (ones_d > CNT_W'(N_SAMPLES / 2));
                cnt_out_q <= ones_d;
            end
        end
    end

`ifdef BPUF_STABILITY_CHECK_EN
    logic unst_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            unst_q <= 1'b0;
        end else if (last_i) begin
            unst_q <= (ones_d != '0) && (ones_d != CNT_W'(N_SAMPLES));
        end
    end

    assign unstable_o = unst_q;
`else
    assign unstable_o = 1'b0;
`endif

    assign valid_o    = valid_q;
    assign resp_o     = resp_q;
    assign ones_cnt_o = cnt_out_q;

endmodule

// File: rtl/bpuf_eval_ctrl.sv
// Excite / settle / sample sequencer for a bank of latch-pair PUF cells.
// Optional BPUF_STABILITY_CHECK_EN adds the unstable_o disagreement flag.
//   state  | meaning
//   IDLE   | waiting for start_i with a valid sel_i
//   EXCITE | excite_o[sel] high, EXCITE_CYC cycles
//   SETTLE | excite released, SETTLE_CYC cycles
//   SAMPLE | N_SAMPLES synchronized Q samples counted
//   DONE   | result published, valid_o pulse
module bpuf_eval_ctrl
    import bpuf_pkg::*;
#(
    parameter int N_CELLS    = DEF_N_CELLS,
    parameter int SEL_W      = $clog2(N_CELLS),
    parameter int EXCITE_CYC = DEF_EXCITE_CYC,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC,
    parameter int N_SAMPLES  = DEF_N_SAMPLES,
    parameter int CNT_W      = cnt_width(N_SAMPLES)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic [SEL_W-1:0]   sel_i,
    output logic [N_CELLS-1:0] excite_o,
    input  logic [N_CELLS-1:0] q_i,
    output logic               busy_o,
    output logic               valid_o,
    output logic               resp_o,
    output logic [CNT_W-1:0]   ones_cnt_o,
    output logic               unstable_o
);

    localparam int TMR_MAX = (EXCITE_CYC > SETTLE_CYC)
                           ? ((EXCITE_CYC > N_SAMPLES) ? EXCITE_CYC : N_SAMPLES)
                           : ((SETTLE_CYC > N_SAMPLES) ? SETTLE_CYC : N_SAMPLES);
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    if (N_SAMPLES % 2 == 0) begin : g_chk_odd
        $error("N_SAMPLES must be odd");
    end
    if (EXCITE_CYC < 1) begin : g_chk_exc
        $error("EXCITE_CYC must be at least 1");
    end
    if (SETTLE_CYC < 2) begin : g_chk_set
        $error("SETTLE_CYC must be at least 2");
    end

    state_e             state_q, state_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [N_CELLS-1:0] excite_q, excite_d;
    logic               busy_q, busy_d;
    logic               clear_s, sample_s, last_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            tmr_q    <= '0;
            sel_q    <= '0;
            excite_q <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            tmr_q    <= tmr_d;
            sel_q    <= sel_d;
            excite_q <= excite_d;
            busy_q   <= busy_d;
        end
    end

    // Timer is a down-counter loaded with (length - 1) on entry to each timed state.
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        sel_d   = sel_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i && (int'(sel_i) < N_CELLS)) begin
                    state_d = ST_EXCITE;
                    sel_d   = sel_i;
                    tmr_d   = TMR_W'(EXCITE_CYC - 1);
                end
            end
            ST_EXCITE: begin
                if (tmr_q == '0) begin
                    state_d = ST_SETTLE;
                    tmr_d   = TMR_W'(SETTLE_CYC - 1);
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            ST_SETTLE: begin
                if (tmr_q == '0) begin
                    state_d = ST_SAMPLE;
                    tmr_d   = TMR_W'(N_SAMPLES - 1);
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            ST_SAMPLE: begin
                if (tmr_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_comb begin
        excite_d = '0;
        if (state_d == ST_EXCITE) begin
            excite_d[sel_d] = 1'b1;
        end
        busy_d = (state_d != ST_IDLE);
    end

    assign clear_s  = (state_q == ST_IDLE) && (state_d == ST_EXCITE);
    assign sample_s = (state_q == ST_SAMPLE);
    assign last_s   = sample_s && (tmr_q == '0);

    bpuf_sample_voter #(
        .N_CELLS   (N_CELLS),
        .SEL_W     (SEL_W),
        .N_SAMPLES (N_SAMPLES),
        .CNT_W     (CNT_W)
    ) u_voter (
        .clk        (clk),
        .rst_n      (rst_n),
        .q_i        (q_i),
        .sel_i      (sel_q),
        .clear_i    (clear_s),
        .sample_i   (sample_s),
        .last_i     (last_s),
        .valid_o    (valid_o),
        .resp_o     (resp_o),
        .ones_cnt_o (ones_cnt_o),
        .unstable_o (unstable_o)
    );

    assign excite_o = excite_q;
    assign busy_o   = busy_q;

endmodule

// File: tb/tb_bpuf_eval_ctrl.sv
// Directed bench for bpuf_eval_ctrl with a cycle-accurate behavioural reference model.
module tb_bpuf_eval_ctrl;

    localparam int N_CELLS = 8;
    localparam int E       = 4;
    localparam int S       = 16;
    localparam int N       = 7;
    localparam int T_VALID = E + S + N + 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_i = 1'b0;
    logic [2:0] sel_i = 3'd0;
    logic [7:0] q_i = 8'h00;
    logic [7:0] excite_o;
    logic       busy_o, valid_o, resp_o, unstable_o;
    logic [2:0] ones_cnt_o;

    bpuf_eval_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start_i),
        .sel_i      (sel_i),
        .excite_o   (excite_o),
        .q_i        (q_i),
        .busy_o     (busy_o),
        .valid_o    (valid_o),
        .resp_o     (resp_o),
        .ones_cnt_o (ones_cnt_o),
        .unstable_o (unstable_o)
    );

    always #5 clk = ~clk;

    int cmp_cnt = 0;
    int err_cnt = 0;
    bit tog_en  = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        cmp_cnt++;
        if (act != exp) begin
            err_cnt++;
            $display("FAIL %s: actual=%0d required=%0d @%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: an evaluation accepted on cycle t0 owns cycles t0+1..t0+T_VALID;
    // the vote covers the cell's Q as seen at cycles t0+E+S-1..t0+E+S+N-2 (two-flop sync).
    logic [7:0] qhist [64];
    int         cyc     = 0;
    int         t0      = -1000;
    int         next_ok = 0;
    int         msel    = 0;
    int         m_ones  = 0;
    logic       m_resp  = 1'b0;
    logic       m_unst  = 1'b0;
    int         r;
    logic [7:0] m_exc;

    always @(posedge clk) begin
        cyc++;
        #1;
        qhist[(cyc - 1) % 64] = q_i;
        if (!rst_n) begin
            t0 = -1000; next_ok = 0; m_ones = 0; m_resp = 1'b0; m_unst = 1'b0;
        end else if ((cyc - 1 >= next_ok) && start_i && (int'(sel_i) < N_CELLS)) begin
            t0 = cyc - 1; msel = int'(sel_i); next_ok = t0 + T_VALID + 1;
        end
        r = cyc - t0;
        if (rst_n && r == T_VALID) begin
            m_ones = 0;
            for (int k = E + S - 1; k <= E + S + N - 2; k++) begin
                m_ones += int'(qhist[(t0 + k) % 64][msel]);
            end
            m_resp = (m_ones > N / 2);
`ifdef BPUF_STABILITY_CHECK_EN
            m_unst = (m_ones != 0) && (m_ones != N);
`else
            m_unst = 1'b0;
`endif
        end
        m_exc = (rst_n && r >= 1 && r <= E) ? (8'd1 << msel) : 8'd0;
        chk("m_excite", int'(excite_o), int'(m_exc));
        chk("m_busy", int'(busy_o), int'(rst_n && r >= 1 && r <= T_VALID));
        chk("m_valid", int'(valid_o), int'(rst_n && r == T_VALID));
        chk("m_resp", int'(resp_o), int'(m_resp));
        chk("m_ones", int'(ones_cnt_o), m_ones);
        chk("m_unstable", int'(unstable_o), int'(m_unst));
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            if (tog_en) q_i[5] = ~q_i[5];
        end
    endtask

    task automatic run_eval(input logic [2:0] sel, output int lat);
        logic [7:0] one_hot;
        sel_i = sel;
        start_i = 1'b1;
        step(1);
        start_i = 1'b0;
        one_hot = 8'd1 << sel;
        chk("excite_first_cycle", int'(excite_o), int'(one_hot));
        lat = 1;
        while (!valid_o && lat < 60) begin
            step(1);
            lat++;
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int   lat, nval, nbusy, nrise, nv, lastc;
        logic prev_b, multi;
        logic [2:0] ones;

        repeat (3) @(negedge clk);
        chk("rst_excite", int'(excite_o), 0);
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_valid", int'(valid_o), 0);
        chk("rst_ones", int'(ones_cnt_o), 0);
        rst_n = 1'b1;
        step(2);

        // constant 1 on cell 3
        q_i = 8'h08;
        run_eval(3'd3, lat);
        chk("t1_latency", lat, 28);
        chk("t1_ones", int'(ones_cnt_o), 7);
        chk("t1_resp", int'(resp_o), 1);
        chk("t1_unstable", int'(unstable_o), 0);
        step(1);
        chk("t1_valid_pulse", int'(valid_o), 0);
        chk("t1_busy_release", int'(busy_o), 0);
        chk("t1_hold", int'(ones_cnt_o), 7);
        step(2);

        // toggling Q on cell 5
        q_i = 8'h00;
        tog_en = 1'b1;
        run_eval(3'd5, lat);
        ones = ones_cnt_o;
        chk("t2_latency", lat, 28);
        chk("t2_ones_range", int'(ones == 3'd3 || ones == 3'd4), 1);
`ifdef BPUF_STABILITY_CHECK_EN
        chk("t2_unstable", int'(unstable_o), 1);
`else
        chk("t2_unstable", int'(unstable_o), 0);
`endif
        tog_en = 1'b0;
        step(3);

        // start pulses while busy are ignored
        q_i = 8'h02;
        sel_i = 3'd1;
        start_i = 1'b1;
        step(1);
        start_i = 1'b0;
        nval = 0; nbusy = 0; nrise = 0; prev_b = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            nval  += int'(valid_o);
            nbusy += int'(busy_o);
            if (busy_o && !prev_b) nrise++;
            prev_b  = busy_o;
            start_i = (c == 2 || c == 10);
            if (c == 2) sel_i = 3'd6;
            step(1);
        end
        start_i = 1'b0;
        chk("t3_valid_count", nval, 1);
        chk("t3_busy_cycles", nbusy, 28);
        chk("t3_busy_restarts", nrise, 0);
        chk("t3_resp", int'(resp_o), 1);

        // reset during SAMPLE
        q_i = 8'h10;
        sel_i = 3'd4;
        start_i = 1'b1;
        step(1);
        start_i = 1'b0;
        step(22);
        chk("t4_busy_before", int'(busy_o), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t4_excite", int'(excite_o), 0);
        chk("t4_busy", int'(busy_o), 0);
        chk("t4_valid", int'(valid_o), 0);
        chk("t4_resp", int'(resp_o), 0);
        chk("t4_ones", int'(ones_cnt_o), 0);
        step(3);
        rst_n = 1'b1;
        step(1);
        run_eval(3'd4, lat);
        chk("t4_latency", lat, 28);
        chk("t4_ones_after", int'(ones_cnt_o), 7);
        step(2);

        // start held high, alternating cells 0 and 7
        q_i = 8'h01;
        sel_i = 3'd0;
        start_i = 1'b1;
        step(1);
        nv = 0; lastc = 0; multi = 1'b0;
        for (int c = 1; c <= 150 && nv < 4; c++) begin
            if ($countones(excite_o) > 1) multi = 1'b1;
            if (valid_o) begin
                if (nv > 0) chk("t5_period", c - lastc, 29);
                lastc = c;
                nv++;
                sel_i = (sel_i == 3'd0) ? 3'd7 : 3'd0;
            end
            step(1);
        end
        start_i = 1'b0;
        chk("t5_evals", nv, 4);
        chk("t5_excite_onehot", int'(multi), 0);
        step(35);

        // only the selected cell contributes
        q_i = 8'hFB;
        run_eval(3'd2, lat);
        chk("t6_latency", lat, 28);
        chk("t6_ones", int'(ones_cnt_o), 0);
        chk("t6_resp", int'(resp_o), 0);
        chk("t6_unstable", int'(unstable_o), 0);
        step(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
